amiq_sock_tx_framer: RTL

Synthesizable transmit-side framer for the socket link. It collects one message from a DUT-side byte stream and buffers it whole. It then emits a length-prefixed, checksummed byte frame toward the simulation socket connector, which forwards bytes to the server. It is the hardware counterpart of the connector's data path, producing exactly the byte stream the connector sends.

---
 rtl/amiq_sock_tx_framer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/amiq_sock_tx_framer.sv
// ============================================================================
// Module      : amiq_sock_tx_framer
// Description : Transmit framer for the socket link. It buffers one message,
//               then emits it as SOF, LEN, payload, CKSUM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amiq_sock_tx_framer #(
  parameter int         MAX_LEN  = 16,
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             busy,
  output logic             err_trunc,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int               c_AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]       c_LEN_LAST = 8'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_DROP    = 3'd1,
    ST_HDR_SOF = 3'd2,
    ST_HDR_LEN = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CKSUM   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_len;
  logic [7:0]       r_cksum;
  logic [7:0]       r_rd_ptr;
  logic             r_err_trunc;
  logic [CNT_W-1:0] r_frames_sent;
  logic [7:0]       r_buf [MAX_LEN];

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_data      = 8'h00;
    case (r_state)
      ST_COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last)
            w_state_nxt = ST_HDR_SOF;
          else if (r_len == c_LEN_LAST)
            w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last)
          w_state_nxt = ST_HDR_SOF;
      end
      ST_HDR_SOF: begin
        m_valid = 1'b1;
        m_data  = SOF_BYTE;
        if (m_ready)
          w_state_nxt = ST_HDR_LEN;
      end
      ST_HDR_LEN: begin
        m_valid = 1'b1;
        m_data  = r_len;
        if (m_ready)
          w_state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        m_valid = 1'b1;
        m_data  = r_buf[r_rd_ptr[c_AW-1:0]];
        if (m_ready && (r_rd_ptr == r_len - 8'd1))
          w_state_nxt = ST_CKSUM;
      end
      ST_CKSUM: begin
        m_valid = 1'b1;
        m_data  = r_cksum ^ r_len;
        if (m_ready)
          w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_COLLECT;
      r_len         <= 8'd0;
      r_cksum       <= 8'd0;
      r_rd_ptr      <= 8'd0;
      r_err_trunc   <= 1'b0;
      r_frames_sent <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_COLLECT: begin
          if (s_valid) begin
            r_len   <= r_len + 8'd1;
            r_cksum <= r_cksum ^ s_data;
            if (!s_last && (r_len == c_LEN_LAST))
              r_err_trunc <= 1'b1;
          end
        end
        ST_HDR_LEN: begin
          if (m_ready)
            r_rd_ptr <= 8'd0;
        end
        ST_PAYLOAD: begin
          if (m_ready)
            r_rd_ptr <= r_rd_ptr + 8'd1;
        end
        ST_CKSUM: begin
          if (m_ready) begin
            r_frames_sent <= r_frames_sent + c_CNT_ONE;
            r_len         <= 8'd0;
            r_cksum       <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; only bytes below r_len are ever read.
  always_ff @(posedge clk) begin
    if ((r_state == ST_COLLECT) && s_valid)
      r_buf[r_len[c_AW-1:0]] <= s_data;
  end

  assign busy        = (r_state != ST_COLLECT) && (r_state != ST_DROP);
  assign err_trunc   = r_err_trunc;
  assign frames_sent = r_frames_sent;

endmodule

`default_nettype wire
